seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle radix-2 restoring divider; inverse of the registered multiplier datapath.
//   Takes a 2*DATA_W dividend (e.g. a product) and a DATA_W divisor.
//   Returns a DATA_W quotient and remainder with error flags.
//   Operands are registered on start; results are registered and held until the next accepted start.
// PARAMETERS
//   DATA_W  32  divisor/quotient/remainder width; dividend width is 2*DATA_W
// PORTS
//   clk          in   1         rising-edge clock (single clock domain)
//   rst          in   1         asynchronous, active-low reset
//   start        in   1         request; accepted only in IDLE
//   dividend     in   2*DATA_W  sampled on the accepting edge
//   divisor      in   DATA_W    sampled on the accepting edge
//   busy         out  1         high in RUN, FIX and DONE
//   done         out  1         one-cycle pulse; results valid from this cycle
//   quotient     out  DATA_W    held until next accepted start
//   remainder    out  DATA_W    held until next accepted start
//   div_by_zero  out  1         divisor was 0; held with results
//   overflow     out  1         quotient not representable in DATA_W; held with results
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; all outputs and internal registers are 0. Reset mid-operation aborts with no done.
//   FSM states: IDLE, RUN, FIX, DONE.
//   Cycle numbering: start is sampled high at the edge ending cycle 0.
//   IDLE, start=1: register operands; clear flags.
//     divisor==0 -> DONE; div_by_zero=1, quotient=all-ones, remainder=dividend[DATA_W-1:0].
//     Else if dividend[2W-1:W] >= divisor (unsigned) -> DONE; overflow=1, quotient=all-ones, remainder=0.
//     Else -> RUN; iteration counter = 0.
//     Error results: done=1 in cycle 1.
//   RUN: one restoring step per cycle.
//     Shift {rem,quo} left by 1; trial-subtract divisor from the DATA_W+1-bit partial remainder.
//     Keep the difference if it is non-negative; the quotient LSB is the non-negative bit.
//     After DATA_W steps (counter wraps at DATA_W-1) -> DONE, or -> FIX in the signed build.
//   FIX: signed build only; sign correction, one cycle.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE; busy drops in that IDLE cycle.
//   Latency, unsigned normal path: done=1 in cycle DATA_W+1 (33 for default).
//   start while busy=1 (RUN/FIX/DONE): ignored; no queuing.
//   Earliest re-start: the IDLE cycle right after DONE.
//   Outputs change only on accepted start (cleared) or at the DONE transition (loaded).
//   Invariant (unsigned, no error): dividend == quotient*divisor + remainder, remainder < divisor.
// CONFIGURATION
//   DIVIDER_SIGNED_EN undefined: operands and results are unsigned.
//   DIVIDER_SIGNED_EN defined: operands and results are two's complement.
//     Divide magnitudes; quotient sign = sign(dividend) XOR sign(divisor).
//     Remainder sign = sign(dividend), i.e. truncating division.
//     Overflow check is made on magnitudes at start.
//     FIX also flags overflow if the final quotient magnitude exceeds 2^(W-1)-1 (positive result)
//       or 2^(W-1) (negative result); on overflow, quotient=all-ones and remainder=0.
//     Normal-path latency is DATA_W+2 (34); error paths unchanged (cycle 1).
//     div_by_zero in the signed build: remainder = dividend[W-1:0].
// TESTING
//   1. dividend=64'd1000, divisor=32'd7, unsigned
//      -> cycle 33: done=1, quotient=142, remainder=6; flags 0.
//   2. dividend=64'hFFFFFFFE_00000001, divisor=32'hFFFFFFFF
//      -> quotient=32'hFFFFFFFF, remainder=0, overflow=0.
//   3. divisor=0, dividend=64'h0000_0005_1234_5678
//      -> cycle 1: done=1, div_by_zero=1, quotient=32'hFFFFFFFF, remainder=32'h12345678.
//   4. dividend=64'h1_00000000, divisor=1
//      -> cycle 1: overflow=1, quotient=32'hFFFFFFFF, remainder=0.
//   5. start pulsed again during RUN -> ignored; first result unchanged, exactly one done.
//      Then rst=0 in cycle 10 of a new op -> outputs 0 immediately, no done.
//      Next start completes normally.
//   6. DIVIDER_SIGNED_EN: dividend=-1000, divisor=7
//      -> cycle 34: quotient=32'hFFFFFF72 (-142), remainder=32'hFFFFFFFA (-6).
//   Random: 10k unsigned pairs vs. reference model; check the invariant and the single-pulse done.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, 2*DATA_W dividend / DATA_W divisor.
// Results and error flags are registered and held until the next accepted start.
// Build macro DIVIDER_SIGNED_EN: when defined, operands and results are two's complement
// (truncating division, one extra FIX cycle for sign correction); undefined gives unsigned.
module seq_divider #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2*DATA_W-1:0]   dividend,
   input  logic [DATA_W-1:0]     divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_W-1:0]     quotient,
   output logic [DATA_W-1:0]     remainder,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] ALL_ONES  = '1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t               state;
   state_t               state_next;

   // Working registers: partial remainder, quotient/low-dividend shift register, divisor magnitude.
   logic [DATA_W-1:0]    part_rem;
   logic [DATA_W-1:0]    part_quo;
   logic [DATA_W-1:0]    dsr;
   logic [CNT_W-1:0]     step_cnt;

   // Operand decode at start: magnitudes (identity in the unsigned build) and error detection.
   logic                 dvd_neg;
   logic                 dsr_neg;
   logic [2*DATA_W-1:0]  dvd_mag;
   logic [DATA_W-1:0]    dsr_mag;
   logic                 start_dbz;
   logic                 start_ovf;

`ifdef DIVIDER_SIGNED_EN
   assign dvd_neg = dividend[2*DATA_W-1];
   assign dsr_neg = divisor[DATA_W-1];
`else
   assign dvd_neg = 1'b0;
   assign dsr_neg = 1'b0;
`endif

   assign dvd_mag   = dvd_neg ? -dividend : dividend;
   assign dsr_mag   = dsr_neg ? -divisor : divisor;
   assign start_dbz = (divisor == '0);
   // The quotient fits in DATA_W bits only if the upper dividend half is below the divisor.
   assign start_ovf = (dvd_mag[2*DATA_W-1:DATA_W] >= dsr_mag);

   // One restoring step: shift in the next dividend bit, trial-subtract, keep if non-negative.
   logic [DATA_W:0]      trial_rem;
   logic                 trial_ge;
   logic [DATA_W-1:0]    trial_diff;
   logic [DATA_W-1:0]    step_rem;
   logic [DATA_W-1:0]    step_quo;

   assign trial_rem  = {part_rem, part_quo[DATA_W-1]};
   assign trial_ge   = (trial_rem >= {1'b0, dsr});
   // When the trial succeeds the difference is below the divisor, so DATA_W bits suffice.
   assign trial_diff = trial_rem[DATA_W-1:0] - dsr;
   assign step_rem   = trial_ge ? trial_diff : trial_rem[DATA_W-1:0];
   assign step_quo   = {part_quo[DATA_W-2:0], trial_ge};

`ifdef DIVIDER_SIGNED_EN
   // Sign correction: result signs captured at start, magnitude limits checked in FIX.
   logic                 quo_neg;
   logic                 rem_neg;
   logic [DATA_W-1:0]    quo_limit;
   logic                 fix_ovf;

   assign quo_limit = quo_neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   assign fix_ovf   = (part_quo > quo_limit);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and the busy/done status outputs.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = (start_dbz || start_ovf) ? DONE : RUN;
            end
         end
         RUN: begin
            if (step_cnt == LAST_STEP) begin
`ifdef DIVIDER_SIGNED_EN
               state_next = FIX;
`else
               state_next = DONE;
`endif
            end
         end
         FIX: begin
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, iterate in RUN, load results when entering DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         part_rem    <= '0;
         part_quo    <= '0;
         dsr         <= '0;
         step_cnt    <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         quo_neg     <= 1'b0;
         rem_neg     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  part_rem    <= dvd_mag[2*DATA_W-1:DATA_W];
                  part_quo    <= dvd_mag[DATA_W-1:0];
                  dsr         <= dsr_mag;
                  step_cnt    <= '0;
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                  quo_neg     <= dvd_neg ^ dsr_neg;
                  rem_neg     <= dvd_neg;
`endif
                  // Error results skip RUN and are visible in the very next (DONE) cycle.
                  if (start_dbz) begin
                     div_by_zero <= 1'b1;
                     quotient    <= ALL_ONES;
                     remainder   <= dividend[DATA_W-1:0];
                  end else if (start_ovf) begin
                     overflow    <= 1'b1;
                     quotient    <= ALL_ONES;
                  end
               end
            end
            RUN: begin
               part_rem <= step_rem;
               part_quo <= step_quo;
               step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + CNT_W'(1);
`ifdef DIVIDER_SIGNED_EN
`else
               if (step_cnt == LAST_STEP) begin
                  quotient  <= step_quo;
                  remainder <= step_rem;
               end
`endif
            end
`ifdef DIVIDER_SIGNED_EN
            FIX: begin
               if (fix_ovf) begin
                  overflow  <= 1'b1;
                  quotient  <= ALL_ONES;
                  remainder <= '0;
               end else begin
                  quotient  <= quo_neg ? -part_quo : part_quo;
                  remainder <= rem_neg ? -part_rem : part_rem;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against a timeline model.
// The model predicts acceptance, done cycle and held results from plain arithmetic.
module tb_seq_divider;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [63:0]   dividend;
   logic [31:0]   divisor;
   logic          busy;
   logic          done;
   logic [31:0]   quotient;
   logic [31:0]   remainder;
   logic          div_by_zero;
   logic          overflow;

   seq_divider #(.DATA_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Model state: the operation in flight and the results currently held.
   logic          op_active  = 1'b0;
   int            acc_cyc    = 0;
   int            op_lat     = 0;
   int            busy_until = -1;
   logic [63:0]   op_a       = '0;
   logic [31:0]   op_b       = '0;
   logic [31:0]   new_q = '0, new_r = '0, cur_q = '0, cur_r = '0;
   logic          new_dz = 1'b0, new_ov = 1'b0, cur_dz = 1'b0, cur_ov = 1'b0;
   int            done_seen     = 0;
   int            last_done_cyc = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference division from the arithmetic definition; lat is the done cycle after accept.
   function automatic void ref_div(input logic [63:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic dz, output logic ov, output int lat);
      logic [63:0] am, bm, qm, rm;
      logic        an, bn;
`ifdef DIVIDER_SIGNED_EN
      an = a[63];
      bn = b[31];
`else
      an = 1'b0;
      bn = 1'b0;
`endif
      am  = an ? -a : a;
      bm  = {32'b0, (bn ? -b : b)};
      q   = '1;
      r   = '0;
      dz  = 1'b0;
      ov  = 1'b0;
      lat = 1;
      if (b == 32'd0) begin
         dz = 1'b1;
         r  = a[31:0];
      end else if (am[63:32] >= bm[31:0]) begin
         ov = 1'b1;
      end else begin
         qm = am / bm;
         rm = am % bm;
`ifdef DIVIDER_SIGNED_EN
         lat = W + 2;
         if ((!(an ^ bn) && qm > 64'h7FFF_FFFF) || ((an ^ bn) && qm > 64'h8000_0000)) begin
            ov = 1'b1;
         end else begin
            q = (an ^ bn) ? -qm[31:0] : qm[31:0];
            r = an ? -rm[31:0] : rm[31:0];
         end
`else
         lat = W + 1;
         q   = qm[31:0];
         r   = rm[31:0];
`endif
      end
   endfunction

   // Compare process: every cycle, checks all outputs against the model timeline.
   logic [31:0] e_q, e_r;
   logic        e_dz, e_ov, e_busy, e_done, at_done;
   always @(negedge clk) begin
      at_done = 1'b0;
      if (!rst) begin
         e_q = '0; e_r = '0; e_dz = 1'b0; e_ov = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else if (op_active && cyc < acc_cyc + op_lat) begin
         e_q = '0; e_r = '0; e_dz = 1'b0; e_ov = 1'b0; e_busy = 1'b1; e_done = 1'b0;
      end else if (op_active && cyc == acc_cyc + op_lat) begin
         e_q = new_q; e_r = new_r; e_dz = new_dz; e_ov = new_ov; e_busy = 1'b1; e_done = 1'b1;
         at_done = 1'b1;
      end else begin
         e_q = cur_q; e_r = cur_r; e_dz = cur_dz; e_ov = cur_ov; e_busy = 1'b0; e_done = 1'b0;
      end
      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_done));
      check("quotient", 64'(quotient), 64'(e_q));
      check("remainder", 64'(remainder), 64'(e_r));
      check("div_by_zero", 64'(div_by_zero), 64'(e_dz));
      check("overflow", 64'(overflow), 64'(e_ov));
      if (done === 1'b1) begin
         done_seen++;
         last_done_cyc = cyc;
      end
      if (at_done) begin
         $display("op %h / %h -> q=%h r=%h dz=%0d ov=%0d lat=%0d",
                  op_a, op_b, quotient, remainder, div_by_zero, overflow, op_lat);
`ifndef DIVIDER_SIGNED_EN
         if (!new_dz && !new_ov) begin
            check("invariant", {32'b0, quotient} * {32'b0, op_b} + {32'b0, remainder}, op_a);
            check("rem_lt_div", 64'(remainder < op_b), 64'd1);
         end
`endif
         cur_q = new_q; cur_r = new_r; cur_dz = new_dz; cur_ov = new_ov;
         op_active = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // One-cycle start pulse; the model accepts it only if the divider is idle in that cycle.
   task automatic issue(input logic [63:0] a, input logic [31:0] b);
      tick();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      if (cyc > busy_until) begin
         op_active = 1'b1;
         acc_cyc   = cyc;
         op_a      = a;
         op_b      = b;
         ref_div(a, b, new_q, new_r, new_dz, new_ov, op_lat);
         busy_until = cyc + op_lat;
      end
      tick();
      start = 1'b0;
   endtask

   // Returns in the done cycle of the current operation (earliest restart follows).
   task automatic wait_done();
      int n;
      n = 0;
      while (cyc < busy_until && n < 100) begin
         tick();
         n++;
      end
      if (cyc < busy_until) begin
         total++;
         bad++;
         $display("FAIL wait_done: cycle %0d, expected done by %0d", cyc, busy_until);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst        = 1'b0;
      op_active  = 1'b0;
      busy_until = -1;
      cur_q = '0; cur_r = '0; cur_dz = 1'b0; cur_ov = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_quotient", 64'(quotient), 64'd0);
      repeat (cycles) tick();
      rst = 1'b1;
   endtask

   logic [31:0] mq, mr;
   logic        mdz, mov;
   int          mlat;
   int          d0;
   logic [63:0] ra;
   logic [31:0] rb;
   int          kind;
   int          n;

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

`ifndef DIVIDER_SIGNED_EN
      // Pin the model with hand-computed results.
      ref_div(64'd1000, 32'd7, mq, mr, mdz, mov, mlat);
      check("model_q_1000_7", 64'(mq), 64'd142);
      check("model_r_1000_7", 64'(mr), 64'd6);
      check("model_lat_1000_7", 64'(mlat), 64'd33);
      ref_div(64'h0000_0001_0000_0000, 32'd1, mq, mr, mdz, mov, mlat);
      check("model_ovf", 64'({mov, mq}), 64'h1_FFFF_FFFF);

      issue(64'd1000, 32'd7);
      wait_done();
      check("t1_q", 64'(quotient), 64'd142);
      check("t1_r", 64'(remainder), 64'd6);
      check("t1_lat", 64'(last_done_cyc - acc_cyc), 64'd33);

      issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
      wait_done();
      check("t2_q", 64'(quotient), 64'hFFFF_FFFF);
      check("t2_r_ovf", 64'({overflow, remainder}), 64'd0);

      issue(64'h0000_0005_1234_5678, 32'd0);
      wait_done();
      check("t3_q", 64'(quotient), 64'hFFFF_FFFF);
      check("t3_r", 64'(remainder), 64'h1234_5678);
      check("t3_dz_lat", 64'({div_by_zero, 8'(last_done_cyc - acc_cyc)}), 64'h101);

      issue(64'h0000_0001_0000_0000, 32'd1);
      wait_done();
      check("t4_ovf_q", 64'({overflow, quotient}), 64'h1_FFFF_FFFF);
      check("t4_r", 64'(remainder), 64'd0);
`else
      ref_div(64'hFFFF_FFFF_FFFF_FC18, 32'd7, mq, mr, mdz, mov, mlat);
      check("model_sq", 64'(mq), 64'hFFFF_FF72);
      check("model_sr", 64'(mr), 64'hFFFF_FFFA);
      check("model_slat", 64'(mlat), 64'd34);

      issue(64'hFFFF_FFFF_FFFF_FC18, 32'd7);
      wait_done();
      check("t6_q", 64'(quotient), 64'hFFFF_FF72);
      check("t6_r", 64'(remainder), 64'hFFFF_FFFA);
      check("t6_lat", 64'(last_done_cyc - acc_cyc), 64'd34);
`endif

      // Start pulses while busy are ignored; exactly one done for the first operation.
      d0 = done_seen;
      issue(64'd1000, 32'd7);
      repeat (3) begin
         repeat (4) tick();
         issue(64'd99, 32'd3);
      end
      wait_done();
      check("t5_q", 64'(quotient), 64'd142);
      tick();
      tick();
      check("t5_one_done", 64'(done_seen - d0), 64'd1);

      // Reset in cycle 10 of an operation aborts it with no done.
      d0 = done_seen;
      issue(64'd5000, 32'd9);
      while (cyc < acc_cyc + 10) tick();
      do_reset(2);
      repeat (40) tick();
      check("t5_no_done_after_rst", 64'(done_seen - d0), 64'd0);
      issue(64'd5000, 32'd9);
      wait_done();
`ifndef DIVIDER_SIGNED_EN
      check("t5_after_rst_q", 64'(quotient), 64'd555);
      check("t5_after_rst_r", 64'(remainder), 64'd5);
`endif

      // Randomized operands across normal, boundary and error classes.
      for (int i = 0; i < 1200; i++) begin
         kind = $urandom_range(0, 9);
         rb   = $urandom;
         ra   = {32'($urandom), 32'($urandom)};
         if (kind == 0) begin
            rb = '0;
         end else if (kind == 1) begin
            ra[63:32] = rb | 32'($urandom);
         end else begin
            if (kind < 4) rb = 32'($urandom_range(1, 255));
            if (rb == 32'd0) rb = 32'd1;
            if (kind == 4) ra = {rb - 32'd1, 32'hFFFF_FFFF};
            else ra[63:32] = 32'($urandom) % rb;
         end
         issue(ra, rb);
         if ($urandom_range(0, 3) == 0) begin
            n = 0;
            while (cyc < busy_until && n < 100) begin
               if ($urandom_range(0, 5) == 0) issue({32'($urandom), 32'($urandom)}, 32'($urandom));
               else tick();
               n++;
            end
         end else begin
            wait_done();
         end
      end
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
